// File: rtl/spi_pkg.sv
// Shared constants and types for the mode-0 SPI slave front end.
package spi_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int SPI_MODE   = 0;

    typedef enum logic {IDLE, ACTIVE} state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one SPI pin, with a history flop for edge detection.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;
endmodule

// File: rtl/spi_slave_core.sv
// Mode-0 SPI slave, MSB first, oversampled in the system clock domain.
// Received bytes go out with a valid pulse; replies come from a one-entry buffer.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              SPI_Clk,
    input  logic              SPI_MOSI,
    input  logic              SPI_CS,
    output logic              SPI_MISO,
    output logic              SPI_MISO_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_err,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);

    logic       sclk_lvl, sclk_rise, sclk_fall;
    logic       cs_lvl, cs_rise, cs_fall;
    logic       mosi_lvl;
    logic [1:0] mosi_edge_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(Clk), .rst(reset), .din(SPI_Clk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(Clk), .rst(reset), .din(SPI_CS),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(Clk), .rst(reset), .din(SPI_MOSI),
        .level(mosi_lvl), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
    );

    state_e            state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              byte_done_q, byte_done_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_full_q, tx_full_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              frame_err_q, frame_err_d;
    logic              take_tx;

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        miso_d        = miso_q;
        byte_done_d   = 1'b0;
        // rx_data and rx_valid land together, one cycle after the last bit shifts in
        rx_valid_d    = byte_done_q;
        rx_data_d     = byte_done_q ? rx_shift_q : rx_data_q;
        tx_underrun_d = 1'b0;
        frame_err_d   = 1'b0;
        oe_d          = ~cs_lvl;
        take_tx       = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    take_tx   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    miso_d      = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_lvl};
                    if (bit_cnt_q == CW'(DATA_W - 1)) begin
                        bit_cnt_d   = '0;
                        byte_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], tx_shift_q[DATA_W-1]};
                        miso_d     = tx_shift_q[DATA_W-2];
                    end else begin
                        take_tx = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An empty buffer at a byte boundary sends zeros and flags the underrun
        if (take_tx) begin
            tx_shift_d    = tx_full_q ? tx_buf_q : '0;
            miso_d        = tx_full_q & tx_buf_q[DATA_W-1];
            tx_underrun_d = ~tx_full_q;
            tx_full_d     = 1'b0;
        end
        if (tx_load && !tx_full_q) begin
            tx_full_d = 1'b1;
            tx_buf_d  = tx_data;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            byte_done_q   <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_shift_q    <= '0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            miso_q        <= 1'b0;
            oe_q          <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            byte_done_q   <= byte_done_d;
            rx_valid_q    <= rx_valid_d;
            tx_shift_q    <= tx_shift_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            miso_q        <= miso_d;
            oe_q          <= oe_d;
            tx_underrun_q <= tx_underrun_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign SPI_MISO    = miso_q;
    assign SPI_MISO_oe = oe_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~tx_full_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave_core.sv
// Bench: a bit-banging SPI master plus an event-level model of the slave,
// checked against the DUT on every system clock.
module tb_spi_slave_core;
    logic       Clk = 1'b0;
    logic       reset;
    logic       SPI_Clk, SPI_MOSI, SPI_CS;
    logic       SPI_MISO, SPI_MISO_oe;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, tx_load, tx_ready, tx_underrun, frame_err, busy;

    spi_slave_core #(.SYNC_STAGES(2), .DATA_W(8)) dut (
        .Clk(Clk), .reset(reset), .SPI_Clk(SPI_Clk), .SPI_MOSI(SPI_MOSI),
        .SPI_CS(SPI_CS), .SPI_MISO(SPI_MISO), .SPI_MISO_oe(SPI_MISO_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_load(tx_load), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    endtask

    // Abstract slave model: frame state, received bits, reply buffer.
    bit         m_active, m_full;
    int         m_bits;
    logic [7:0] m_rx, m_val;
    logic [7:0] miso_q[$];
    // Output events keyed by the cycle they must appear in
    bit         ev_rxv[int], ev_und[int], ev_fe[int], ev_rdy[int], ev_busy[int];
    logic [7:0] ev_rxd[int];
    logic [7:0] e_rxd;
    bit         e_rdy, e_busy;

    int n_rxv = 0, n_und = 0, n_fe = 0, last_rxv_cyc = 0, last_rise = 0;
    logic [7:0] last_miso;
    logic [7:0] got_q[$];
    logic [7:0] f_bytes[$];
    int         f_reply[$];

    always @(negedge Clk) begin
        if (!reset) begin
            if (ev_rdy.exists(cyc))  e_rdy  = ev_rdy[cyc];
            if (ev_busy.exists(cyc)) e_busy = ev_busy[cyc];
            if (ev_rxv.exists(cyc))  e_rxd  = ev_rxd[cyc];
            chk("rx_valid",    32'(rx_valid),    32'(ev_rxv.exists(cyc)));
            chk("rx_data",     32'(rx_data),     32'(e_rxd));
            chk("tx_underrun", 32'(tx_underrun), 32'(ev_und.exists(cyc)));
            chk("frame_err",   32'(frame_err),   32'(ev_fe.exists(cyc)));
            chk("tx_ready",    32'(tx_ready),    32'(e_rdy));
            chk("busy",        32'(busy),        32'(e_busy));
            chk("miso_oe",     32'(SPI_MISO_oe), 32'(e_busy));
            if (rx_valid) begin n_rxv++; last_rxv_cyc = cyc; end
            if (tx_underrun) n_und++;
            if (frame_err) n_fe++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic consume(input int at);
        if (m_full) begin
            miso_q.push_back(m_val);
            ev_rdy[at] = 1'b0 == 1'b0;
            m_full = 1'b0;
        end else begin
            miso_q.push_back(8'h00);
            ev_und[at] = 1'b1;
        end
    endtask

    // Drive the pins now; the slave reacts three clocks later.
    task automatic pins(input logic cs, input logic sclk, input logic mosi);
        int t   = cyc + 3;
        bit csr = cs & !SPI_CS;
        bit csf = !cs & SPI_CS;
        bit sr  = sclk & !SPI_Clk;
        bit sf  = !sclk & SPI_Clk;
        SPI_CS = cs; SPI_Clk = sclk; SPI_MOSI = mosi;
        if (m_active && csr) begin
            if (m_bits != 0) ev_fe[t] = 1'b1;
            ev_busy[t] = 1'b0;
            m_active = 1'b0;
        end else if (!m_active && csf) begin
            m_active = 1'b1; m_bits = 0;
            ev_busy[t] = 1'b1;
            consume(t);
        end else if (m_active) begin
            if (sr) begin
                m_rx = {m_rx[6:0], mosi};
                m_bits = (m_bits + 1) % 8;
                if (m_bits == 0) begin ev_rxv[t+1] = 1'b1; ev_rxd[t+1] = m_rx; end
            end
            if (sf && m_bits == 0) consume(t);
        end
    endtask

    task automatic load(input logic [7:0] v);
        tx_data = v; tx_load = 1'b1;
        if (!m_full) begin m_full = 1'b1; m_val = v; ev_rdy[cyc+1] = 1'b0; end
        tick();
        tx_load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        SPI_CS = 1'b1; SPI_Clk = 1'b0; SPI_MOSI = 1'b0; tx_load = 1'b0;
        m_active = 0; m_bits = 0; m_full = 0; m_rx = 0;
        miso_q.delete(); ev_rxv.delete(); ev_rxd.delete(); ev_und.delete();
        ev_fe.delete(); ev_rdy.delete(); ev_busy.delete();
        e_rxd = 8'h00; e_rdy = 1'b1; e_busy = 1'b0;
        #1;
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data",  32'(rx_data), 0);
        chk("rst_miso",     32'(SPI_MISO), 0);
        chk("rst_oe",       32'(SPI_MISO_oe), 0);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_underrun", 32'(tx_underrun), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_busy",     32'(busy), 0);
        tick(3);
        reset = 1'b0;
        tick(3);
    endtask

    // Master: CS low, nbits clocks with half period hp, then CS and SCLK released together.
    task automatic run_frame(input int nbits, input int hp);
        logic [7:0] got = 8'h00;
        logic [7:0] cur;
        cur = f_bytes[0];
        pins(1'b0, 1'b0, cur[7]);
        tick(hp);
        for (int i = 0; i < nbits; i++) begin
            cur = f_bytes[i/8];
            pins(1'b0, 1'b1, cur[7-(i%8)]);
            got = {got[6:0], SPI_MISO};
            if (i % 8 == 7) begin
                last_rise = cyc; last_miso = got; got_q.push_back(got);
                chk("miso_byte", 32'(got), 32'(miso_q.pop_front()));
            end
            if (i % 8 == 0 && f_reply.size() > i/8 && f_reply[i/8] >= 0) begin
                load(8'(f_reply[i/8]));
                tick(hp - 1);
            end else tick(hp);
            if (i == nbits - 1) pins(1'b1, 1'b0, 1'b0);
            else begin
                cur = f_bytes[(i+1)/8];
                pins(1'b0, 1'b0, cur[7-((i+1)%8)]);
            end
            tick(hp);
        end
        if (nbits % 8 != 0 && miso_q.size() > 0) void'(miso_q.pop_front());
        tick(6);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int r0, u0, f0, nb, nbits;
        reset = 1'b1; SPI_CS = 1'b1; SPI_Clk = 1'b0; SPI_MOSI = 1'b0;
        tx_load = 1'b0; tx_data = 8'h00;
        tick(2);
        do_reset();

        // single byte with a preloaded reply
        load(8'hA5);
        r0 = n_rxv; u0 = n_und;
        f_bytes = '{8'h3C}; f_reply = '{-1};
        run_frame(8, 4);
        chk("t2_rx_data", 32'(rx_data), 32'h3C);
        chk("t2_miso", 32'(last_miso), 32'hA5);
        chk("t2_rxv_count", n_rxv - r0, 1);
        chk("t2_rxv_latency", last_rxv_cyc - last_rise, 4);
        chk("t2_no_underrun", n_und - u0, 0);

        // three back-to-back bytes, only two replies available
        load(8'h11);
        r0 = n_rxv; u0 = n_und; got_q.delete();
        f_bytes = '{8'h01, 8'h80, 8'hFF}; f_reply = '{8'h22, -1, -1};
        run_frame(24, 4);
        chk("t3_rxv_count", n_rxv - r0, 3);
        chk("t3_underrun_count", n_und - u0, 1);
        chk("t3_rx_last", 32'(rx_data), 32'hFF);
        chk("t3_nbytes", got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("t3_miso0", 32'(got_q[0]), 32'h11);
            chk("t3_miso1", 32'(got_q[1]), 32'h22);
            chk("t3_miso2", 32'(got_q[2]), 32'h00);
        end

        // partial frame, then a clean one
        r0 = n_rxv; f0 = n_fe;
        f_bytes = '{8'hA5}; f_reply = '{-1};
        run_frame(5, 4);
        chk("t4_frame_err", n_fe - f0, 1);
        chk("t4_no_rxv", n_rxv - r0, 0);
        chk("t4_busy", 32'(busy), 0);
        f_bytes = '{8'hC3};
        run_frame(8, 5);
        chk("t4_rx_after", 32'(rx_data), 32'hC3);

        // second load while full is dropped
        load(8'h55);
        load(8'h66);
        chk("t5_ready_full", 32'(tx_ready), 0);
        f_bytes = '{8'h5A}; f_reply = '{-1};
        run_frame(8, 4);
        chk("t5_miso_kept", 32'(last_miso), 32'h55);

        // reset in the middle of a frame
        load(8'h77);
        pins(1'b0, 1'b0, 1'b1); tick(4);
        for (int k = 0; k < 4; k++) begin
            pins(1'b0, 1'b1, 1'b1); tick(4);
            pins(1'b0, 1'b0, 1'b0); tick(4);
        end
        do_reset();
        u0 = n_und;
        f_bytes = '{8'h96}; f_reply = '{-1};
        run_frame(8, 4);
        chk("t6_miso_zero", 32'(last_miso), 32'h00);
        chk("t6_underrun", n_und - u0, 1);
        chk("t6_rx", 32'(rx_data), 32'h96);

        // random traffic against the model
        for (int f = 0; f < 30; f++) begin
            nb = 1 + int'($urandom_range(2));
            f_bytes.delete(); f_reply.delete();
            for (int b = 0; b < nb; b++) begin
                f_bytes.push_back(8'($urandom));
                f_reply.push_back(($urandom % 2 == 1) ? int'($urandom % 256) : -1);
            end
            nbits = 8 * nb;
            if ($urandom % 5 == 0) nbits = 8 * (nb - 1) + 1 + int'($urandom_range(6));
            if ($urandom % 2 == 1) load(8'($urandom));
            run_frame(nbits, 4 + int'($urandom_range(2)));
        end

        tick(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
